dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_memory port between the CPU core
// (load/store path) and an external port (program loader / debug).
//
// One access runs at a time: IDLE picks a winner and latches its request,
// ACCESS drives the memory strobes for MEM_LAT cycles, RESP pulses the
// owner's ack for one cycle. Read data is captured into a per-port register
// that changes only on that port's read completions.
//
// Ports:
//   clk, reset               clock; async active-low reset
//   core_req/we/addr/wdata   core request (req is a level held until ack)
//   core_rdata, core_ack     core read data register, one-cycle completion
//   core_stall               core_req & ~core_ack (holds the PC)
//   ext_*                    same set for the external port (no stall)
//   mem_re/we/addr/wdata     data_memory strobes and latched address/data
//   mem_rdata                data_memory read data
//   busy                     high outside IDLE
//   grant_ext                owner of the current or most recent grant
//
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (ext wins every
// tie); when undefined, ties alternate round-robin starting with the core.

module dmem_arbiter #(
  parameter int DW      = 12,
  parameter int AW      = 12,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  output logic          core_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_ext
);

  localparam int CW = 4;  // holds MEM_LAT-1 for MEM_LAT up to 15

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic          pick_ext;
  req_t          core_r, ext_r, win;

  assign core_r = {core_we, core_addr, core_wdata};
  assign ext_r  = {ext_we, ext_addr, ext_wdata};

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick_ext = ext_req;
`else
  // last_ext resets to 1 so the core takes the first tie.
  logic last_ext;
  assign pick_ext = ext_req & (~core_req | ~last_ext);
`endif

  assign win        = pick_ext ? ext_r : core_r;
  assign core_stall = core_req & ~core_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      ext_rdata  <= '0;
      core_ack   <= 1'b0;
      ext_ack    <= 1'b0;
      busy       <= 1'b0;
      grant_ext  <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_ext   <= 1'b1;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (core_req | ext_req) begin
            lat_we    <= win.we;
            mem_addr  <= win.addr;
            mem_wdata <= win.wdata;
            mem_re    <= ~win.we;
            mem_we    <= win.we;   // write strobe only in the first ACCESS cycle
            grant_ext <= pick_ext;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_ext  <= pick_ext;
`endif
            cnt       <= CW'(MEM_LAT - 1);
            busy      <= 1'b1;
            st        <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (cnt == '0) begin
            mem_re <= 1'b0;
            // grant_ext is the owner for the whole access
            if (!lat_we) begin
              if (grant_ext) ext_rdata  <= mem_rdata;
              else           core_rdata <= mem_rdata;
            end
            core_ack <= ~grant_ext;
            ext_ack  <= grant_ext;
            st       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          core_ack <= 1'b0;
          ext_ack  <= 1'b0;
          busy     <= 1'b0;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiters (MEM_LAT = 1 and 3) each with a behavioural
// data_memory. Directed table of single accesses, hand sequences for reset,
// tie arbitration and mid-access reset, then random two-port traffic checked
// against a transaction-level memory / read-data model.

module tb_dmem_arbiter;
  localparam int DW = 12;
  localparam int AW = 12;
  localparam int NI = 2;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0]         core_req, core_we, core_ack, core_stall;
  logic [NI-1:0]         ext_req, ext_we, ext_ack;
  logic [NI-1:0]         mem_re, mem_we, busy, grant_ext;
  logic [NI-1:0][AW-1:0] core_addr, ext_addr, mem_addr;
  logic [NI-1:0][DW-1:0] core_wdata, core_rdata, ext_wdata, ext_rdata;
  logic [NI-1:0][DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    if (a == 12'h005) return 12'hA5C;
    return DW'(32'(a) * 32'd37 + 32'h5A1);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] mem [4096];
    bit            wr  [4096];

    dmem_arbiter #(.DW(DW), .AW(AW), .MEM_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .core_req(core_req[g]), .core_we(core_we[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_rdata(core_rdata[g]), .core_ack(core_ack[g]),
      .core_stall(core_stall[g]),
      .ext_req(ext_req[g]), .ext_we(ext_we[g]), .ext_addr(ext_addr[g]),
      .ext_wdata(ext_wdata[g]), .ext_rdata(ext_rdata[g]), .ext_ack(ext_ack[g]),
      .mem_re(mem_re[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .grant_ext(grant_ext[g])
    );

    always @(posedge clk) begin
      if (mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
        wr[mem_addr[g]]  <= 1'b1;
      end
    end
    assign mem_rdata[g] = wr[mem_addr[g]] ? mem[mem_addr[g]] : init_pat(mem_addr[g]);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int g, input bit p, input bit r, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!p) begin
      core_req[g] = r; core_we[g] = we; core_addr[g] = a; core_wdata[g] = d;
    end else begin
      ext_req[g] = r; ext_we[g] = we; ext_addr[g] = a; ext_wdata[g] = d;
    end
  endtask

  function automatic logic ack_of(input int g, input bit p);
    return p ? ext_ack[g] : core_ack[g];
  endfunction

  function automatic logic [DW-1:0] rd_of(input int g, input bit p);
    return p ? ext_rdata[g] : core_rdata[g];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One isolated access from IDLE; returns observed counts, -1 latency on timeout.
  task automatic access(input int g, input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output int nre,
                        output int nwe, output int nst, output int nbusy,
                        output logic [DW-1:0] rd, output logic [AW-1:0] sa,
                        output logic [DW-1:0] sd);
    bit done = 1'b0;
    lat = 0; nre = 0; nwe = 0; nst = 0; nbusy = 0; rd = '0; sa = '0; sd = '0;
    drive(g, p, 1'b1, we, a, d);
    #1;
    if (core_stall[g]) nst++;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      lat++;
      if (mem_re[g]) nre++;
      if (mem_we[g]) begin nwe++; sd = mem_wdata[g]; end
      if (mem_re[g] | mem_we[g]) sa = mem_addr[g];
      if (busy[g]) nbusy++;
      if (ack_of(g, p)) begin
        rd = rd_of(g, p);
        done = 1'b1;
      end else if (core_stall[g]) nst++;
    end
    drive(g, p, 1'b0, we, a, d);
    if (!done) lat = -1;
    @(negedge clk);
  endtask

  typedef struct {
    bit            p;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;  // owner's rdata after the access
  } vec_t;

  vec_t tbl[9];

  // Random two-port traffic against a memory + rdata model.
  task automatic run_random(input int g);
    logic [DW-1:0] ref_mem [4096];
    logic [DW-1:0] ref_rd [2];
    bit            act [2];
    int            left [2], gap [2], wt [2];
    bit            cwe [2];
    logic [AW-1:0] ca [2];
    logic [DW-1:0] cd [2];
    int            lat, cyc;
    lat = (g == 0) ? 1 : 3;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_pat(AW'(i));
    do_reset();
    for (int p = 0; p < 2; p++) begin
      ref_rd[p] = '0; act[p] = 1'b0; left[p] = 40; gap[p] = $urandom_range(0, 3); wt[p] = 0;
    end
    cyc = 0;
    while ((left[0] > 0 || left[1] > 0 || act[0] || act[1]) && cyc < 20000) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && left[p] > 0) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            cwe[p] = $urandom_range(0, 1) == 1;
            ca[p]  = AW'(12'h100 + $urandom_range(0, 63));
            cd[p]  = DW'($urandom);
            act[p] = 1'b1; wt[p] = 0; left[p]--;
            drive(g, p[0], 1'b1, cwe[p], ca[p], cd[p]);
          end
        end
      end
      @(negedge clk);
      cyc++;
      chk("rnd_ack_excl", 64'(core_ack[g] & ext_ack[g]), 64'(0));
      chk("rnd_strobe_idle", 64'((mem_re[g] | mem_we[g]) & ~busy[g]), 64'(0));
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          wt[p]++;
          if (ack_of(g, p[0])) begin
            if (cwe[p]) begin
              ref_mem[ca[p]] = cd[p];
              chk("rnd_wr_hold", 64'(rd_of(g, p[0])), 64'(ref_rd[p]));
            end else begin
              ref_rd[p] = ref_mem[ca[p]];
              chk("rnd_rd_data", 64'(rd_of(g, p[0])), 64'(ref_rd[p]));
            end
            chk("rnd_other_rd", 64'(rd_of(g, ~p[0])), 64'(ref_rd[1-p]));
            chk("rnd_grant", 64'(grant_ext[g]), 64'(p));
            chk("rnd_lat_min", 64'(wt[p] >= lat + 1), 64'(1));
            // Round-robin bounds each wait to one foreign access plus its own.
            if (!(FIXED && p == 0))
              chk("rnd_lat_max", 64'(wt[p] <= 2 * lat + 4), 64'(1));
            act[p] = 1'b0;
            gap[p] = $urandom_range(0, 3);
            drive(g, p[0], 1'b0, cwe[p], ca[p], cd[p]);
          end else if (wt[p] > 2000) begin
            chk("rnd_timeout", 64'(wt[p]), 64'(0));
            act[p] = 1'b0; left[p] = 0;
            drive(g, p[0], 1'b0, cwe[p], ca[p], cd[p]);
          end
        end
      end
    end
    chk("rnd_done", 64'(cyc < 20000), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat, nre, nwe, nst, nbusy;
    logic [DW-1:0] rd, sd;
    logic [AW-1:0] sa;
    logic [DW-1:0] last [2];
    bit ec, ee, es;

    reset = 1'b0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    ext_req  = '0; ext_we  = '0; ext_addr  = '0; ext_wdata  = '0;

    // Reset held with both requests up: everything stays 0.
    drive(0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000);
    drive(0, 1'b1, 1'b1, 1'b0, 12'h001, 12'h000);
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++)
        chk("rst_outputs", 64'({mem_re[g], mem_we[g], mem_addr[g], mem_wdata[g], core_rdata[g],
                                ext_rdata[g], core_ack[g], ext_ack[g], busy[g], grant_ext[g]}), 64'(0));
    end
    reset = 1'b1;

    // Both requests held for four accesses.
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      ec = 1'b0; ee = 1'b0;
      if (j % 3 == 2) begin
        if (FIXED || j == 5 || j == 11) ee = 1'b1;
        else                            ec = 1'b1;
      end
      es = (j <= 11) && !ec;
      chk("tie_ack_stall", 64'({core_ack[0], ext_ack[0], core_stall[0]}), 64'({ec, ee, es}));
      if (j == 1) chk("first_grant", 64'(grant_ext[0]), 64'(FIXED));
      if (j == 11) begin
        drive(0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        drive(0, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000);
      end
    end

    // Directed single accesses, MEM_LAT = 1.
    tbl[0] = '{1'b1, 1'b1, 12'h010, 12'h3F1, 12'h000};
    tbl[1] = '{1'b0, 1'b0, 12'h010, 12'h000, 12'h3F1};
    tbl[2] = '{1'b0, 1'b0, 12'h005, 12'h000, 12'hA5C};
    tbl[3] = '{1'b1, 1'b0, 12'h005, 12'h000, 12'hA5C};
    tbl[4] = '{1'b0, 1'b1, 12'h020, 12'h123, 12'hA5C};
    tbl[5] = '{1'b1, 1'b0, 12'h020, 12'h000, 12'h123};
    tbl[6] = '{1'b0, 1'b0, 12'hFFF, 12'h000, 12'h57C};
    tbl[7] = '{1'b1, 1'b1, 12'h005, 12'h777, 12'h123};
    tbl[8] = '{1'b0, 1'b0, 12'h005, 12'h000, 12'h777};
    do_reset();
    last[0] = '0; last[1] = '0;
    for (int i = 0; i < 9; i++) begin
      access(0, tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, lat, nre, nwe, nst, nbusy, rd, sa, sd);
      chk("tbl_latency", 64'(lat), 64'(2));
      chk("tbl_re_cycles", 64'(nre), 64'(tbl[i].we ? 0 : 1));
      chk("tbl_we_cycles", 64'(nwe), 64'(tbl[i].we ? 1 : 0));
      chk("tbl_busy_cycles", 64'(nbusy), 64'(2));
      chk("tbl_stall_cycles", 64'(nst), 64'(tbl[i].p ? 0 : 2));
      chk("tbl_rdata", 64'(rd), 64'(tbl[i].exp));
      chk("tbl_mem_addr", 64'(sa), 64'(tbl[i].a));
      if (tbl[i].we) chk("tbl_mem_wdata", 64'(sd), 64'(tbl[i].d));
      last[tbl[i].p] = tbl[i].exp;
      chk("tbl_other_rdata", 64'(rd_of(0, ~tbl[i].p)), 64'(last[~tbl[i].p]));
      chk("tbl_grant_ext", 64'(grant_ext[0]), 64'(tbl[i].p));
      chk("tbl_idle_after", 64'({busy[0], mem_re[0], mem_we[0]}), 64'(0));
    end

    // MEM_LAT = 3: write then read.
    access(1, 1'b0, 1'b1, 12'h030, 12'h456, lat, nre, nwe, nst, nbusy, rd, sa, sd);
    chk("lat3_wr_we", 64'(nwe), 64'(1));
    chk("lat3_wr_re", 64'(nre), 64'(0));
    chk("lat3_wr_latency", 64'(lat), 64'(4));
    access(1, 1'b0, 1'b0, 12'h005, 12'h000, lat, nre, nwe, nst, nbusy, rd, sa, sd);
    chk("lat3_rd_re", 64'(nre), 64'(3));
    chk("lat3_rd_we", 64'(nwe), 64'(0));
    chk("lat3_rd_latency", 64'(lat), 64'(4));
    chk("lat3_rd_busy", 64'(nbusy), 64'(4));
    chk("lat3_rd_stall", 64'(nst), 64'(4));
    chk("lat3_rd_data", 64'(rd), 64'(12'hA5C));

    // Reset in the second ACCESS cycle discards the access.
    drive(1, 1'b0, 1'b1, 1'b0, 12'h005, 12'h000);
    repeat (2) @(negedge clk);
    chk("midrst_pre_re", 64'(mem_re[1]), 64'(1));
    reset = 1'b0;
    #1;
    chk("midrst_outputs", 64'({mem_re[1], busy[1], core_ack[1], core_rdata[1], mem_addr[1]}), 64'(0));
    drive(1, 1'b0, 1'b0, 1'b0, 12'h005, 12'h000);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_ack", 64'(core_ack[1]), 64'(0));
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_quiet", 64'({core_ack[1], ext_ack[1], busy[1]}), 64'(0));
    end
    access(1, 1'b0, 1'b0, 12'h005, 12'h000, lat, nre, nwe, nst, nbusy, rd, sa, sd);
    chk("midrst_retry_latency", 64'(lat), 64'(4));
    chk("midrst_retry_data", 64'(rd), 64'(12'hA5C));

    run_random(0);
    run_random(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
